// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// the default reset PC, bubble word and PC step.
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DELIVER = 2'd1,
    DRAIN   = 2'd2
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with redirect load, +4 increment and synchronous
// active-low reset; load takes priority over increment.
module if_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc,
  output logic [31:0] pc_next_seq
);

  // Wrap from 32'hFFFF_FFFC to 0 falls out of the 32-bit add.
  assign pc_next_seq = pc + PC_INC;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc_next_seq;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// presents one word at a time to IF/ID, with branch flush and drain.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic        kill;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        pc_inc;

  // PC stays on the old request address during DRAIN so imem_addr is stable
  // until the ack; the redirect target waits in br_target.
  always_comb begin
    pc_load      = 1'b0;
    pc_load_addr = br_addr;
    pc_inc       = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack && br_taken) pc_load = 1'b1;
        else if (imem_ack)        pc_inc  = 1'b1;
      end
      DELIVER: begin
        if (br_taken) pc_load = 1'b1;
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_load      = 1'b1;
          pc_load_addr = br_taken ? br_addr : br_target;
        end
      end
      default: ;
    endcase
  end

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (pc_load),
    .load_addr   (pc_load_addr),
    .inc         (pc_inc),
    .pc          (pc),
    .pc_next_seq (pc_plus4)
  );

  // Request is gated by rst so nothing is issued while reset is held.
  assign imem_req  = rst && (state != DELIVER);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      valid       <= 1'b0;
      instruction <= NOP_WORD;
      pc_out      <= '0;
      kill        <= 1'b0;
      br_target   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack && !br_taken) begin
            instruction <= imem_rdata;
            pc_out      <= pc_plus4;
            valid       <= 1'b1;
            state       <= DELIVER;
          end else if (!imem_ack && br_taken) begin
            br_target <= br_addr;
            kill      <= 1'b1;
            state     <= DRAIN;
          end
        end
        DELIVER: begin
          if (br_taken || !freeze) begin
            valid       <= 1'b0;
            instruction <= NOP_WORD;
            state       <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack && kill) begin
            kill  <= 1'b0;
            state <= FETCH;
          end else if (br_taken) begin
            br_target <= br_addr;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, fetch/deliver, freeze, flush, drain,
// same-cycle ack+branch, last-redirect-wins, PC wrap and reset during drain.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .instruction (instruction),
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; br_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    step(); step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instruction, NOP); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_fetch();
    step();
    imem_ack = 1'b1; imem_rdata = 32'h2001_000A; freeze = 1'b1;
    step();
    imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%b exp=1", valid); end
    total++; if (instruction !== 32'h2001_000A) begin bad++; $display("FAIL fetch_instr got=%h exp=2001000a", instruction); end
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL fetch_pc_out got=%h exp=4", pc_out); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL freeze_req[%0d] got=%b exp=0", i, imem_req); end
      total++; if (valid !== 1'b1 || instruction !== 32'h2001_000A || pc_out !== 32'h4) begin
        bad++; $display("FAIL freeze_hold[%0d] got v=%b i=%h p=%h exp v=1 i=2001000a p=4", i, valid, instruction, pc_out);
      end
      if (i < 2) step();
    end
    freeze = 1'b0;
    step();
    total++; if (valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL consume got v=%b i=%h exp v=0 i=%h", valid, instruction, NOP); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL next_req got r=%b a=%h exp r=1 a=4", imem_req, imem_addr); end
  endtask

  task automatic test_flush_deliver();
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    step();
    imem_ack = 1'b0;
    total++; if (valid !== 1'b1 || pc_out !== 32'h8) begin bad++; $display("FAIL deliver2 got v=%b p=%h exp v=1 p=8", valid, pc_out); end
    freeze = 1'b1; br_taken = 1'b1; br_addr = 32'h40;
    step();
    br_taken = 1'b0; freeze = 1'b0;
    total++; if (valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL flush_valid got v=%b i=%h exp v=0 i=%h", valid, instruction, NOP); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL flush_req got r=%b a=%h exp r=1 a=40", imem_req, imem_addr); end
  endtask

  task automatic test_drain();
    step();
    br_taken = 1'b1; br_addr = 32'h80;
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || valid !== 1'b0) begin
        bad++; $display("FAIL drain_hold[%0d] got r=%b a=%h v=%b exp r=1 a=40 v=0", i, imem_req, imem_addr, valid);
      end
      if (i == 0) step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    total++; if (valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL drain_discard got v=%b i=%h exp v=0 i=%h", valid, instruction, NOP); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin bad++; $display("FAIL drain_next got r=%b a=%h exp r=1 a=80", imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; br_taken = 1'b1; br_addr = 32'h100;
    step();
    imem_ack = 1'b0; br_taken = 1'b0;
    total++; if (valid !== 1'b0 || instruction !== NOP) begin bad++; $display("FAIL same_cycle_valid got v=%b i=%h exp v=0 i=%h", valid, instruction, NOP); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL same_cycle_req got r=%b a=%h exp r=1 a=100", imem_req, imem_addr); end
  endtask

  task automatic test_last_redirect();
    br_taken = 1'b1; br_addr = 32'h200;
    step();
    br_addr = 32'h300;
    step();
    br_taken = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    step();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 32'h300 || valid !== 1'b0) begin bad++; $display("FAIL last_redirect got a=%h v=%b exp a=300 v=0", imem_addr, valid); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; br_taken = 1'b1; br_addr = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0; imem_rdata = 32'h7777_0001;
    step();
    imem_ack = 1'b0;
    total++; if (valid !== 1'b1 || pc_out !== 32'h0 || instruction !== 32'h7777_0001) begin
      bad++; $display("FAIL wrap_deliver got v=%b p=%h i=%h exp v=1 p=0 i=77770001", valid, pc_out, instruction);
    end
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got r=%b a=%h exp r=1 a=0", imem_req, imem_addr); end
  endtask

  task automatic test_reset_drain();
    br_taken = 1'b1; br_addr = 32'h400;
    step();
    br_taken = 1'b0;
    total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL pre_reset_drain got r=%b a=%h exp r=1 a=0", imem_req, imem_addr); end
    rst = 1'b0;
    step();
    total++; if (imem_req !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL reset_drain got r=%b v=%b exp r=0 v=0", imem_req, valid); end
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL reset_drain_req got r=%b a=%h exp r=1 a=0", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
    step();
    imem_ack = 1'b0;
    total++; if (valid !== 1'b1 || pc_out !== 32'h4) begin bad++; $display("FAIL post_reset_fetch got v=%b p=%h exp v=1 p=4", valid, pc_out); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_freeze();
    test_flush_deliver();
    test_drain();
    test_back_to_back();
    test_last_redirect();
    test_wrap();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, is the instruction value presented whenever valid=0.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 freeze  in  1  hazard stall from downstream; when high, the presented instruction is not consumed.
REQ-006 br_taken  in  1  branch redirect from ID stage, one-cycle qualified pulse.
REQ-007 br_addr  in  32  redirect target byte address, sampled when br_taken=1.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request byte address, equal to the current PC.
REQ-010 imem_ack  in  1  one-cycle pulse completing the outstanding request.
REQ-011 imem_rdata  in  32  instruction word, valid only while imem_ack=1.
REQ-012 pc_out  out  32  PC+4 of the presented instruction, consumed by the IF/ID register.
REQ-013 instruction  out  32  presented instruction word.
REQ-014 valid  out  1  presented instruction is real; low means bubble.

Function
REQ-015 Internal PC register: 32 bits, byte address, increments by 4 modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
REQ-016 FSM states: FETCH, DELIVER, DRAIN.
REQ-017 FETCH: imem_req=1, imem_addr=PC; on imem_ack with br_taken=0: instruction<=imem_rdata, pc_out<=PC+4, PC<=PC+4, valid<=1, next DELIVER.
REQ-018 Handshake: once imem_req rises, imem_req and imem_addr are held stable until imem_ack; exactly one ack per request.
REQ-019 DELIVER: imem_req=0; instruction, pc_out and valid are held stable while freeze=1.
REQ-020 DELIVER with freeze=0 and br_taken=0: the word is consumed at that edge; valid<=0, instruction<=NOP_WORD, next FETCH.
REQ-021 Latency: imem_ack at edge n gives valid=1 after edge n; the next request is issued one cycle after consumption.
REQ-022 br_taken in DELIVER, with freeze at any value: valid<=0, instruction<=NOP_WORD, PC<=br_addr, next FETCH; a flush overrides freeze.
REQ-023 br_taken in FETCH with imem_ack=0: PC target<=br_addr, kill flag set, next DRAIN; imem_req and imem_addr stay on the old request.
REQ-024 DRAIN: imem_req=1 on the old address; the acked word is discarded, valid stays 0, PC<=stored target, next FETCH.
REQ-025 br_taken and imem_ack in the same FETCH cycle: the returned word is discarded, PC<=br_addr, next FETCH; valid stays 0.
REQ-026 br_taken in DRAIN: the stored target is replaced by the newest br_addr; the last redirect wins.
REQ-027 freeze has no effect in FETCH or DRAIN.
REQ-028 valid=0 implies instruction=NOP_WORD at all times.

Reset
REQ-029 While rst=0, at each edge: PC<=RESET_PC, state<=FETCH, valid<=0, instruction<=NOP_WORD, pc_out<=0, kill flag<=0.
REQ-030 imem_req is forced to 0 while rst=0; the first request to RESET_PC is issued in the first cycle with rst=1.
REQ-031 Reset mid-request abandons the outstanding request; the memory shares rst and drops its pending ack.

Structure
REQ-032 The shared package holds the FSM state encoding, NOP_WORD, the RESET_PC default and the PC increment constant (4).
REQ-033 One sub-module, if_pc_reg, holds the PC register with load (redirect), increment and synchronous active-low reset.

Verification
REQ-034 Reset release, ack one cycle after request: addr 0, rdata 32'h2001_000A -> valid=1, instruction=32'h2001_000A, pc_out=4; next request at addr 4.
REQ-035 freeze=1 for 3 cycles in DELIVER -> outputs stable and imem_req=0 for all 3 cycles; after freeze drops -> request at addr 4.
REQ-036 br_taken=1, br_addr=32'h40 in DELIVER with freeze=1 -> valid=0 next cycle, then imem_req=1 at addr 32'h40.
REQ-037 ack latency 3, br_taken (br_addr=32'h80) one cycle after request -> imem_addr held until ack, returned word never valid, next request at 32'h80.
REQ-038 imem_ack and br_taken (br_addr=32'h100) in the same cycle -> valid stays 0, next request at 32'h100.
REQ-039 rst=0 during DRAIN -> imem_req=0, valid=0; after release, request at RESET_PC.
